mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (rs → a, rt → b) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Results become visible after a fixed latency, signalled by `busy`; the pipeline stalls on `busy`.
- HI/LO are read combinationally for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5: cycles `busy` stays high after an accepted MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10: cycles `busy` stays high after an accepted DIV/DIVU (must be ≥1).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset; clk is the only clock.
- pc, input, 32: PC of the issuing instruction, used only for the trace.
- start, input, 1: issue strobe, sampled at posedge.
- op, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- a, input, 32: operand from the register-file RD1 (rs).
- b, input, 32: operand from the register-file RD2 (rt).
- busy, output, 1: registered; high while an operation is in flight.
- hi, output, 32: HI register, driven directly.
- lo, output, 32: LO register, driven directly.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result=0.
  - Asserting reset mid-operation aborts it; no commit occurs.
- FSM states: IDLE and RUN.
- IDLE, start=1, op in {0..3}:
  - Compute the full result from a/b at this edge and latch it into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4 (MTHI) or op=5 (MTLO):
  - hi←a (MTHI) or lo←a (MTLO) at this edge, visible the next cycle.
  - busy stays 0 and the state stays IDLE.
- IDLE, start=1, op in {6,7}: ignored.
- RUN:
  - counter decrements every edge.
  - At the edge where counter==1: hi←pend_hi, lo←pend_lo, busy←0, state←IDLE.
  - busy is therefore high for exactly N cycles, and the new hi/lo appear in the same cycle busy falls.
- start while busy=1: ignored entirely, including MTHI/MTLO. hi/lo and the counter are unaffected. The upstream stall guarantees this never happens legitimately.
- A new op may be accepted in the first cycle busy=0 (back-to-back issue).
- MULT: signed 32×32 → 64; hi=[63:32], lo=[31:0].
- MULTU: unsigned 32×32 → 64; hi=[63:32], lo=[31:0].
- DIV: signed; lo=quotient truncated toward zero, hi=remainder carrying the dividend's sign.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Division by zero (b==0, DIV or DIVU):
  - busy still runs DIV_CYCLES.
  - At commit, hi/lo keep their previous values.
- DIV with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no exception.
- hi/lo outputs never change except at a commit edge, an MTHI/MTLO edge, or reset.

Optional Feature:
- Macro: MDU_TRACE_EN.
- Defined: at every commit edge that changes hi/lo, and at every MTHI/MTLO write, $display a line "@<pc hex>: HI <= <hex>" and/or "@<pc hex>: LO <= <hex>".
  - For mult/div, pc is the value latched at issue.
  - A latched-PC register exists only in this configuration.
- Undefined: no display statements and no PC register; the pc port is unused.
- RTL behaviour is identical in both configurations.

Test Plan:
- Reset: hold reset=0 with clk running → busy=0, hi=0, lo=0. Release, then apply MTLO with a=0x12345678 → lo=0x12345678 next cycle, busy never rises.
- MULT, a=0xFFFFFFFE, b=3 → busy high exactly 5 cycles; at fall hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV, a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 → lo=3, hi=1.
- Preload hi=0xAAAA0000, lo=0x0000BBBB via MTHI/MTLO, then DIVU b=0 → busy for 10 cycles, hi/lo unchanged. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Issue MULT, then pulse start with MTHI a=0xDEADBEEF and with DIV during busy → both ignored; only the MULT result commits; counter unaffected.
- Issue DIV, drive reset=0 on cycle 4 of busy → immediate busy=0, hi=lo=0; no later commit after reset release. Back-to-back MULT issued on the busy-fall cycle is accepted.

Source files
------------

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with HI/LO registers (optional trace: MDU_TRACE_EN)
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = 16;
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]    state;
    logic [CW-1:0] counter;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div0;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] sdiv;
    logic [31:0] udiv;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uuq;
    logic [31:0] uur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    // Full arithmetic results for the operands presented at issue
    always_comb begin
        // low 64 bits of a product of sign-extended operands equal the signed product
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        div0   = (b == 32'd0);
        a_abs  = a[31] ? (32'd0 - a) : a;
        b_abs  = b[31] ? (32'd0 - b) : b;
        // a dummy divisor of 1 keeps the dividers well-defined; the result is discarded on b==0
        sdiv   = div0 ? 32'd1 : b_abs;
        udiv   = div0 ? 32'd1 : b;
        uq     = a_abs / sdiv;
        ur     = a_abs % sdiv;
        // 0x80000000 / -1 wraps back to 0x80000000 through the negation, with remainder 0
        sq     = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
        sr     = a[31] ? (32'd0 - ur) : ur;
        uuq    = a / udiv;
        uur    = a % udiv;
    end

    // Select the pending HI/LO value and whether it should be committed
    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
        case (op)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = sr;  res_lo = sq;  res_wr = !div0; end
            OP_DIVU:  begin res_hi = uur; res_lo = uuq; res_wr = !div0; end
            default:  res_wr = 1'b0;
        endcase
    end

    // Issue/run FSM, HI/LO registers and the pending result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            counter <= op[1] ? DIV_N : MULT_N;
                            state   <= ST_RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifdef MDU_TRACE_EN
    logic [31:0] pc_q;

    // Remember the issuing PC so the commit trace can name it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (state == ST_IDLE && start && !op[2]) begin
            pc_q <= pc;
        end
    end

    // Trace every HI/LO write as it happens
    always @(posedge clk) begin
        if (reset) begin
            if (state == ST_RUN && counter == CW'(1) && pend_wr) begin
                if (pend_hi != hi_q) $display("@%08h: HI <= %08h", pc_q, pend_hi);
                if (pend_lo != lo_q) $display("@%08h: LO <= %08h", pc_q, pend_lo);
            end else if (state == ST_IDLE && start && op == OP_MTHI) begin
                $display("@%08h: HI <= %08h", pc, a);
            end else if (state == ST_IDLE && start && op == OP_MTLO) begin
                $display("@%08h: LO <= %08h", pc, a);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard testbench for mdu_hilo
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .pc(pc), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted operation
    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     p;
        logic [63:0]     q;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; m_hi = r[31:0]; m_lo = q[31:0]; end
            3'd3: if (y != 0) begin q = ux / uy; r = ux % uy; m_hi = r[31:0]; m_lo = q[31:0]; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Drive one start pulse; accepted ops update the model and scoreboard
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        pc = $urandom; start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        model_op(o, x, y);
        if (o < 3'd4) begin
            e.hi = m_hi; e.lo = m_lo; e.cyc = o[1] ? DC : MC;
            exp_q.push_back(e);
        end else begin
            chk("mt_or_nop_hi", {32'd0, hi}, {32'd0, m_hi});
            chk("mt_or_nop_lo", {32'd0, lo}, {32'd0, m_lo});
            chk("mt_or_nop_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    // Pulse start without touching the model (used while busy)
    task automatic poke(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        if (o < 3'd4) wait_idle();
    endtask

    // Monitor: on every busy fall, pop the expected commit and check values and busy length
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_hi", {32'd0, hi}, {32'd0, e.hi});
                        chk("commit_lo", {32'd0, lo}, {32'd0, e.lo});
                        chk("busy_cycles", 64'(cnt), 64'(e.cyc));
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(3'd5, 32'h12345678, 32'h0);
        chk("mtlo_value", {32'd0, lo}, 64'h12345678);

        do_op(3'd0, 32'hFFFFFFFE, 32'd3);
        do_op(3'd1, 32'hFFFFFFFE, 32'd3);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2);
        do_op(3'd3, 32'd7, 32'd2);

        do_op(3'd4, 32'hAAAA0000, 32'd0);
        do_op(3'd5, 32'h0000BBBB, 32'd0);
        do_op(3'd3, 32'h12345678, 32'd0);
        chk("div0_hi_kept", {32'd0, hi}, 64'hAAAA0000);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo", {32'd0, lo}, 64'h80000000);

        // starts during busy must be ignored
        issue(3'd0, 32'h00010001, 32'h00020002);
        poke(3'd4, 32'hDEADBEEF, 32'd0);
        poke(3'd2, 32'd100, 32'd3);
        wait_idle();
        chk("ignored_mthi", {32'd0, hi}, 64'h00000002);

        // reset in the middle of a divide aborts it
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_late_commit_lo", {32'd0, lo}, 64'd0);
        chk("no_late_commit_busy", {63'd0, busy}, 64'd0);

        // back-to-back issue on the first idle cycle
        do_op(3'd0, 32'd6, 32'hFFFFFFF9);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 9));
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            do_op(o, x, y);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
